// File: rtl/equation_pkg.sv
// equation_pkg: shared types and constants for the byte-serial equation recogniser.
// Optional build macro EQUATION_CHAIN_EN (used in equation.sv) allows "a=b=c".
package equation_pkg;

    typedef enum logic [2:0] {
        S_LHS_EXP  = 3'd0,
        S_LHS_OPND = 3'd1,
        S_EQ       = 3'd2,
        S_RHS_OPND = 3'd3,
        S_RHS_OP   = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CC_OPND = 2'd0,
        CC_OP   = 2'd1,
        CC_EQ   = 2'd2,
        CC_BAD  = 2'd3
    } cclass_t;

    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_EQ   = 8'h3D;
    localparam logic [7:0] CH_A_LO = 8'h61;  // 'a'
    localparam logic [7:0] CH_Z_LO = 8'h7A;  // 'z'
    localparam logic [7:0] CH_D0   = 8'h30;  // '0'
    localparam logic [7:0] CH_D9   = 8'h39;  // '9'

endpackage

// File: rtl/equation_char_class.sv
// equation_char_class: combinational ASCII byte -> character class.
// Unknown (X/Z) input falls through every test and lands in CC_BAD.
module equation_char_class
    import equation_pkg::*;
(
    input  logic [7:0] in,
    output cclass_t    cls
);

    // classify the current byte; anything not explicitly recognised is BAD
    always_comb begin
        cls = CC_BAD;
        if ((in >= CH_A_LO && in <= CH_Z_LO) || (in >= CH_D0 && in <= CH_D9))
            cls = CC_OPND;
        else if (in == CH_PLUS || in == CH_STAR)
            cls = CC_OP;
        else if (in == CH_EQ)
            cls = CC_EQ;
    end

endmodule

// File: rtl/equation.sv
// equation: byte-serial syntax checker for "Expr = Expr" with single-char
// operands and '+'/'*' operators. out is high while the stream since reset
// is a complete legal equation.
// Optional build macro EQUATION_CHAIN_EN: a further '=' after a complete
// right-hand side starts another right-hand side instead of erroring.
module equation
    import equation_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic       out
);

    state_t  state, nxt;
    cclass_t cls;

    equation_char_class u_cc (
        .in  (in),
        .cls (cls)
    );

    // state register with synchronous reset taking priority over in
    always_ff @(posedge clk) begin
        if (reset) state <= S_LHS_EXP;
        else       state <= nxt;
    end

    // next-state decode; every unexpected class drops into the sticky error state
    always_comb begin
        nxt = S_ERR;
        case (state)
            S_LHS_EXP:  if (cls == CC_OPND) nxt = S_LHS_OPND;
            S_LHS_OPND: begin
                if (cls == CC_OP)      nxt = S_LHS_EXP;
                else if (cls == CC_EQ) nxt = S_EQ;
            end
            S_EQ:       if (cls == CC_OPND) nxt = S_RHS_OPND;
            S_RHS_OPND: begin
                if (cls == CC_OP) nxt = S_RHS_OP;
`ifdef EQUATION_CHAIN_EN
                else if (cls == CC_EQ) nxt = S_EQ;
`else
                else nxt = S_ERR;
`endif
            end
            S_RHS_OP:   if (cls == CC_OPND) nxt = S_RHS_OPND;
            default:    nxt = S_ERR;
        endcase
    end

    // Moore output: only a just-completed right operand makes a legal equation
    assign out = (state == S_RHS_OPND);

endmodule

// File: tb/tb_equation.sv
// tb_equation: drives directed and random byte streams into equation and
// compares out against a model that re-parses the whole stream since reset.
module tb_equation;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in = 8'h00;
    logic       out;

    int checks = 0;
    int errors = 0;

    logic [7:0] hist[$];

    equation dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic bit is_opnd(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h30 && c <= 8'h39);
    endfunction

    // whole-string grammar check: operands at even positions, operators or '='
    // at odd positions, odd total length, and the right number of '='
    function automatic bit legal(input logic [7:0] q[$]);
        int neq = 0;
        if (q.size() == 0 || q.size() % 2 == 0) return 1'b0;
        foreach (q[i]) begin
            if (i % 2 == 0) begin
                if (!is_opnd(q[i])) return 1'b0;
            end else if (q[i] == 8'h3D) begin
                neq++;
            end else if (q[i] != 8'h2B && q[i] != 8'h2A) begin
                return 1'b0;
            end
        end
`ifdef EQUATION_CHAIN_EN
        return neq >= 1;
`else
        return neq == 1;
`endif
    endfunction

    task automatic step(input logic [7:0] c, input logic rst, input string tag);
        in    = c;
        reset = rst;
        @(posedge clk);
        #1;
        if (rst) hist.delete();
        else     hist.push_back(c);
        chk(tag, out, legal(hist));
    endtask

    task automatic send(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b0, tag);
    endtask

    task automatic rst_step();
        step(8'h00, 1'b1, "rst");
    endtask

    logic [7:0] badset[10] = '{8'h60, 8'h7B, 8'h2F, 8'h3A, 8'h2C,
                               8'h3C, 8'h3E, 8'h41, 8'h20, 8'h00};

    function automatic logic [7:0] rnd_char(input int pos);
        int r = $urandom_range(99);
        if (r < 6)  return badset[$urandom_range(9)];
        if (r < 9)  return 8'($urandom_range(255));
        if (pos % 2 == 0) begin
            if ($urandom_range(1) == 0) return 8'(8'h61 + $urandom_range(25));
            return 8'(8'h30 + $urandom_range(9));
        end
        r = $urandom_range(3);
        if (r == 0) return 8'h3D;
        if (r == 1) return 8'h2B;
        return 8'h2A;
    endfunction

    initial begin
        // reset, then the test-plan streams
        rst_step();
        chk("rst_out0", out, 1'b0);
        send("a+p*0=a", "lhs_rhs");
        chk("complete", out, 1'b1);
        send("*", "trail_op");
        rst_step();
        send("1=2+x", "num");
        rst_step();
        send("ab=c", "dbl_opnd");
        rst_step();
        send("c=d", "after_err");
        rst_step();
        send("=ab", "eq_first");
        rst_step();
        send("+a=b", "op_first");
        rst_step();
        send("aA=b", "upper");
        rst_step();
        send("a=A", "upper_rhs");
        rst_step();
        send("a=b=c", "chain");
        rst_step();
        send("a=b", "pre_rst");
        rst_step();
        chk("rst_mid", out, 1'b0);
        send("z=9", "post_rst");
        rst_step();
        send("a=b+c=d*e", "chain2");
        // boundary operands
        rst_step();
        send("z*9=0+a", "bounds");
        // random streams, occasionally reset mid-stream
        for (int s = 0; s < 60; s++) begin
            int len = $urandom_range(1, 14);
            rst_step();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(39) == 0) begin
                    rst_step();
                end else begin
                    step(rnd_char(hist.size()), 1'b0, "rand");
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
